// File: rtl/led_matrix_scanner.sv
// Double-buffered 8x8 bicolour frame store with a row-scan driver.
// The game logic writes the back buffer row by row and requests a swap;
// the scanner shows the front buffer on the 28-bit led bus and exchanges
// the buffers only when the scan wraps to row 0, so a frame never tears.
module led_matrix_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_row,
    input  logic [7:0]  wr_red,
    input  logic [7:0]  wr_green,
    input  logic        swap_req,
    output logic        swap_done,
    output logic        frame_start,
    output logic [0:27] led
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    // Frame store: index 0/1 selects the buffer, then the row (x).
    logic [7:0]    red_r [0:1][0:7];
    logic [7:0]    grn_r [0:1][0:7];

    logic          front_r;
    logic          swap_pend_r;
    logic [PW-1:0] presc_r;
    logic [2:0]    row_r;
    logic [BW-1:0] blank_r;

    logic          tick_s;
    logic          wrap_s;
    logic          swap_go_s;
    logic          back_s;
    logic          front_next_s;
    logic [2:0]    row_next_s;
    logic [BW-1:0] blank_next_s;
    logic [15:0]   colour_next_s;

    // Row-slot timing: tick on the last prescaler count, wrap on the row-7 tick.
    always_comb begin
        tick_s    = (presc_r == PW'(SCAN_DIV - 1));
        wrap_s    = tick_s && (row_r == 3'd7);
        swap_go_s = wrap_s && (swap_pend_r || swap_req);
        back_s    = ~front_r;
    end

    // Next row, front select and blank count, shared by the state and output registers.
    always_comb begin
        row_next_s   = row_r;
        front_next_s = front_r;
        blank_next_s = blank_r;
        if (tick_s) begin
            row_next_s = row_r + 3'd1;
        end else begin
            row_next_s = row_r;
        end
        if (swap_go_s) begin
            front_next_s = ~front_r;
        end else begin
            front_next_s = front_r;
        end
        if (tick_s) begin
            blank_next_s = BW'(BLANK_CYCLES);
        end else if (blank_r != BW'(0)) begin
            blank_next_s = blank_r - BW'(1);
        end else begin
            blank_next_s = BW'(0);
        end
    end

    // Colour columns for the coming cycle: dark while blanking, else the
    // front row inverted (pixel y=7 lands on the lowest led index of each byte).
    always_comb begin
        colour_next_s = 16'hFFFF;
        if (blank_next_s != BW'(0)) begin
            colour_next_s = 16'hFFFF;
        end else begin
            colour_next_s = {~red_r[front_next_s][row_next_s],
                             ~grn_r[front_next_s][row_next_s]};
        end
    end

    // Prescaler, row counter and blanking counter.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            presc_r <= PW'(0);
            row_r   <= 3'd0;
            blank_r <= BW'(0);
        end else begin
            if (tick_s) begin
                presc_r <= PW'(0);
            end else begin
                presc_r <= presc_r + PW'(1);
            end
            row_r   <= row_next_s;
            blank_r <= blank_next_s;
        end
    end

    // Swap handshake: remember a request until the next frame wrap serves it.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            front_r     <= 1'b0;
            swap_pend_r <= 1'b0;
        end else begin
            front_r <= front_next_s;
            if (swap_go_s) begin
                swap_pend_r <= 1'b0;
            end else if (swap_req) begin
                swap_pend_r <= 1'b1;
            end else begin
                swap_pend_r <= swap_pend_r;
            end
        end
    end

    // Back-buffer row writes; the back buffer is whichever one is not in front.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int x = 0; x < 8; x++) begin
                    red_r[b][x] <= 8'h00;
                    grn_r[b][x] <= 8'h00;
                end
            end
        end else if (wr_en) begin
            red_r[back_s][wr_row] <= wr_red;
            grn_r[back_s][wr_row] <= wr_green;
        end else begin
            red_r[back_s][wr_row] <= red_r[back_s][wr_row];
            grn_r[back_s][wr_row] <= grn_r[back_s][wr_row];
        end
    end

    // Registered outputs: led bus, frame-start and swap-done pulses.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            led         <= {16'hFFFF, 8'hFF, 3'd0, 1'b1};
            swap_done   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            led         <= {colour_next_s, 8'hFF, row_next_s, 1'b1};
            swap_done   <= swap_go_s;
            frame_start <= wrap_s;
        end
    end

    led_matrix_scanner_checker u_checker (
        .CLK         (CLK),
        .reset       (reset),
        .swap_done   (swap_done),
        .frame_start (frame_start),
        .led         (led)
    );

endmodule

// Invariants of the scanner outputs, kept apart from the datapath.
module led_matrix_scanner_checker (
    input logic        CLK,
    input logic        reset,
    input logic        swap_done,
    input logic        frame_start,
    input logic [0:27] led
);

    a_done_on_frame: assert property (@(posedge CLK) disable iff (reset)
        swap_done |-> frame_start);

    a_fixed_bits: assert property (@(posedge CLK) disable iff (reset)
        (led[16:23] == 8'hFF) && led[27]);

    a_frame_pulse: assert property (@(posedge CLK) disable iff (reset)
        frame_start |=> !frame_start);

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner: the driver updates a
// cycle-count based reference model on every clock edge and queues the
// expected outputs; a monitor pops and compares on every falling edge.
module tb_led_matrix_scanner;

    localparam int SD = 4;
    localparam int BL = 1;
    localparam int FR = 8 * SD;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_row = 3'd0;
    logic [7:0]  wr_red = 8'd0;
    logic [7:0]  wr_green = 8'd0;
    logic        swap_req = 1'b0;
    logic        swap_done;
    logic        frame_start;
    logic [0:27] led;
    logic [27:0] led_flat;

    assign led_flat = led;

    led_matrix_scanner #(.SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_red      (wr_red),
        .wr_green    (wr_green),
        .swap_req    (swap_req),
        .swap_done   (swap_done),
        .frame_start (frame_start),
        .led         (led)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [27:0] led;
        logic        done;
        logic        fs;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_push = 0;
    int   n_pop  = 0;
    event async_chk;

    // Reference model: edges since reset release, two frame buffers, pending flag.
    int         m_t;
    logic [7:0] m_red [0:1][0:7];
    logic [7:0] m_grn [0:1][0:7];
    int         m_front;
    bit         m_pend;

    function automatic void push_exp(logic [27:0] l, logic d, logic f);
        exp_t e;
        e.led  = l;
        e.done = d;
        e.fs   = f;
        sb_q.push_back(e);
        n_push++;
    endfunction

    function automatic void model_reset();
        m_t     = 0;
        m_front = 0;
        m_pend  = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int x = 0; x < 8; x++) begin
                m_red[b][x] = 8'h00;
                m_grn[b][x] = 8'h00;
            end
        end
        push_exp(28'hFFFFFF1, 1'b0, 1'b0);
    endfunction

    function automatic void model_edge(bit rst_i, bit we, logic [2:0] wr,
                                       logic [7:0] r, logic [7:0] g, bit sr);
        int          row;
        bit          wrap;
        bit          done;
        bit          blank;
        logic [15:0] col;
        if (rst_i) begin
            model_reset();
            return;
        end
        m_t  = m_t + 1;
        wrap = ((m_t % FR) == 0);
        done = 1'b0;
        if (we) begin
            m_red[1 - m_front][wr] = r;
            m_grn[1 - m_front][wr] = g;
        end
        if (wrap && (m_pend || sr)) begin
            m_front = 1 - m_front;
            m_pend  = 1'b0;
            done    = 1'b1;
        end else if (sr) begin
            m_pend = 1'b1;
        end
        row   = (m_t / SD) % 8;
        blank = (m_t >= SD) && ((m_t % SD) < BL);
        col   = blank ? 16'hFFFF : {~m_red[m_front][row], ~m_grn[m_front][row]};
        push_exp({col, 8'hFF, 3'(row), 1'b1}, done, wrap);
    endfunction

    task automatic check(string name, logic [27:0] act, logic [27:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0d, time %0t)", name, act, exp, m_t, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK or async_chk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_pop++;
                check("led", led_flat, e.led);
                check("swap_done", {27'd0, swap_done}, {27'd0, e.done});
                check("frame_start", {27'd0, frame_start}, {27'd0, e.fs});
            end
        end
    end

    task automatic step(bit rst_i, bit we, logic [2:0] wr, logic [7:0] r,
                        logic [7:0] g, bit sr);
        @(negedge CLK);
        #1;
        reset    = rst_i;
        wr_en    = we;
        wr_row   = wr;
        wr_red   = r;
        wr_green = g;
        swap_req = sr;
        @(posedge CLK);
        model_edge(rst_i, we, wr, r, g, sr);
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge CLK);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        ->async_chk;
    endtask

    initial begin
        model_reset();
        repeat (3) step(1'b1, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);

        // Free-running scan after release: row stepping and frame_start.
        idle(34);

        // Pixel map: row 2 red=01 green=80, then swap.
        step(1'b0, 1'b1, 3'd2, 8'h01, 8'h80, 1'b0);
        step(1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
        idle(40);

        // Write without swap must not reach the display.
        step(1'b0, 1'b1, 3'd5, 8'hFF, 8'h00, 1'b0);
        idle(3 * FR);

        // Swap request coincident with the row-7 tick, another one cycle later.
        for (int i = 0; i < FR && ((m_t + 1) % FR) != 0; i++) idle(1);
        step(1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
        step(1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
        idle(FR + 4);

        // Blanking: full green row 3.
        step(1'b0, 1'b1, 3'd3, 8'h00, 8'hFF, 1'b1);
        idle(2 * FR);

        // Randomised writes and swap requests.
        repeat (1500) begin
            step(1'b0, ($urandom_range(0, 2) == 0), 3'($urandom), 8'($urandom),
                 8'($urandom), ($urandom_range(0, 19) == 0));
        end
        idle(FR);

        // Reset in row 4 with a swap pending.
        for (int i = 0; i < 2 * FR && (((m_t / SD) % 8) != 4 || (m_t % SD) != 0); i++) idle(1);
        step(1'b0, 1'b1, 3'd1, 8'hAA, 8'h55, 1'b1);
        async_reset();
        step(1'b1, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        idle(2 * FR + 4);

        @(negedge CLK);
        #1;
        check("queue_drained", 28'(n_pop), 28'(n_push));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
